branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
Consumer end of the branch prediction interface. Queues each prediction made at fetch, checks it against the actual outcome at execute, and drives the predictor update bus (write, pc_write, branch_result, branch_address). On a mispredict it drives the fetch redirect and pipeline flush. Sits between fetch, the branch predictor and the execute stage.

Parameters:
DEPTH, 4, number of in-flight prediction queue entries; must be a power of 2, minimum 2
FLUSH_CYCLES, 3, cycles spent in FLUSH after a mispredict, including the redirect cycle; minimum 1

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
fetch_valid  in  1  fetch stage holds a valid instruction
fetch_is_branch  in  1  fetched instruction is a branch
fetch_pc  in  32  PC of the fetched branch
pred_taken  in  1  predictor direction for fetch_pc
pred_target  in  32  predictor target for fetch_pc
fetch_stall  out  1  queue full; fetch must hold the branch
ex_valid  in  1  execute resolves one branch this cycle
ex_pc  in  32  PC of the resolving branch
ex_taken  in  1  actual direction
ex_target  in  32  actual taken target
write  out  1  predictor update strobe
pc_write  out  32  PC being updated
branch_result  out  1  actual direction for the update
branch_address  out  32  actual target for the update
redirect  out  1  flush pipeline and redirect fetch
redirect_pc  out  32  correct next PC
seq_error  out  1  sticky: resolution order violated

Behaviour:
- Reset: all outputs 0, queue empty, state RUN, seq_error cleared.
- Queue: circular FIFO of {pc, pred_taken, pred_target}; log2(DEPTH)+1-bit count; pointers wrap modulo DEPTH.
- fetch_stall = (count == DEPTH), taken combinationally from the registered count.
- Push when fetch_valid & fetch_is_branch & ~fetch_stall & state==RUN.
- A push on a full queue is blocked even if a pop occurs in the same cycle.
- Pop when ex_valid & count!=0 & state==RUN. Simultaneous push and pop on a non-full queue leaves count unchanged.
- ex_valid with an empty queue: set seq_error; no update, no redirect.
- Compare against the head entry. Mispredict when any of these hold:
  - ex_taken != head.pred_taken
  - ex_taken & (ex_target != head.pred_target)
  - ex_pc != head.pc; this also sets seq_error
- Update outputs are registered, 1 cycle after the pop:
  - write=1
  - pc_write=ex_pc
  - branch_result=ex_taken
  - branch_address=ex_target
  - write is high exactly one cycle per pop.
- On mispredict, in the same registered cycle:
  - redirect=1 for exactly one cycle
  - redirect_pc = ex_taken ? ex_target : ex_pc+4, with 32-bit wrap (0xFFFFFFFC+4=0)
  - state goes RUN->FLUSH and the queue is cleared.
- FLUSH:
  - A down-counter loads FLUSH_CYCLES-1.
  - ex_valid and fetch pushes are ignored; fetch_stall=0.
  - FLUSH->RUN when the counter reaches 0.
  - For FLUSH_CYCLES=1, FLUSH lasts only the redirect cycle.
- Correct prediction: no redirect, state stays RUN.
- seq_error clears only on reset.
- Reset mid-FLUSH or with a non-empty queue: immediate return to the reset state.

Optional Feature:
BRANCH_RESOLVER_STATS_EN.
- Defined:
  - Adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
  - stat_branches increments on every pop; stat_mispredicts increments on every mispredict.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package bp_pkg:
  - prediction-entry typedef {pc[31:0], taken, target[31:0]}
  - state encoding RUN=0, FLUSH=1
  - PC_STEP=4 constant
- One natural sub-module: pred_queue, the parameterised FIFO with push/pop/clear/count and full/empty. The FSM, compare logic and update registers stay in branch_resolver.

Test Plan:
- Push 0x100 (pred T, 0x200). Resolve ex_pc 0x100, T, 0x200. Next cycle: write=1, pc_write=0x100, branch_result=1, branch_address=0x200, redirect=0.
- Push 0x104 predicted NT. Resolve taken to 0x400. Next cycle: redirect=1, redirect_pc=0x400, write=1. Queue empties; fetch pushes ignored for 3 cycles, then accepted.
- Push 0x108 predicted T. Resolve not-taken. Response: redirect_pc=0x10C, branch_result=0.
- Push 4 branches with no resolution: fetch_stall=1 and the 5th push is blocked. Pop one: fetch_stall=0 next cycle.
- ex_valid with an empty queue: seq_error=1, write=0. Resolve ex_pc 0x200 against head 0x300: seq_error stays 1, redirect=1.
- Assert reset during FLUSH: all outputs 0 immediately. A push on the next cycle after release is accepted.

Source files
------------

// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bp_pkg
//  Purpose  : Shared types and constants for the branch resolver block:
//             prediction queue entry, resolver state encoding, PC step.
//  Revision : 1.0  initial release
// ============================================================================
package bp_pkg;

  // One in-flight prediction as captured at fetch time
  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } pred_entry_t;

  // Resolver state: RUN accepts traffic, FLUSH drains after a redirect
  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Sequential fall-through distance for a not-taken branch
  localparam logic [31:0] PC_STEP = 32'd4;

endpackage
`default_nettype wire

// File: rtl/branch_resolver_if.sv
`default_nettype none
// ============================================================================
//  Module   : branch_resolver_if
//  Purpose  : Fetch / execute / predictor-update bundle for branch_resolver.
//             slave modport is the resolver side, master the environment.
//             Optional macro BRANCH_RESOLVER_STATS_EN adds statistics outputs.
//  Revision : 1.0  initial release
// ============================================================================
interface branch_resolver_if;
  logic        fetch_valid;
  logic        fetch_is_branch;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        fetch_stall;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        write;
  logic [31:0] pc_write;
  logic        branch_result;
  logic [31:0] branch_address;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        seq_error;
`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  modport slave (
    input  fetch_valid, fetch_is_branch, fetch_pc, pred_taken, pred_target,
    input  ex_valid, ex_pc, ex_taken, ex_target,
    output fetch_stall, write, pc_write, branch_result, branch_address,
    output redirect, redirect_pc, seq_error
`ifdef BRANCH_RESOLVER_STATS_EN
    , output stat_branches, stat_mispredicts
`endif
  );

  modport master (
    output fetch_valid, fetch_is_branch, fetch_pc, pred_taken, pred_target,
    output ex_valid, ex_pc, ex_taken, ex_target,
    input  fetch_stall, write, pc_write, branch_result, branch_address,
    input  redirect, redirect_pc, seq_error
`ifdef BRANCH_RESOLVER_STATS_EN
    , input stat_branches, stat_mispredicts
`endif
  );
endinterface
`default_nettype wire

// File: rtl/pred_queue.sv
`default_nettype none
// ============================================================================
//  Module   : pred_queue
//  Purpose  : Circular FIFO of in-flight predictions with push/pop/clear,
//             occupancy count and full/empty flags. DEPTH must be 2^n, >= 2.
//  Revision : 1.0  initial release
// ============================================================================
module pred_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic                   clock,
  input  wire logic                   reset,
  input  wire logic                   i_push,
  input  wire logic                   i_pop,
  input  wire logic                   i_clear,
  input  wire pred_entry_t            i_data,
  output pred_entry_t                 o_head,
  output logic [$clog2(DEPTH):0]      o_count,
  output logic                        o_full,
  output logic                        o_empty
);
  localparam int AW = $clog2(DEPTH);

  pred_entry_t     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_push && !i_pop)      r_count <= r_count + 1'b1;
      else if (i_pop && !i_push) r_count <= r_count - 1'b1;
    end
  end

  // Entry storage; no reset needed since count gates validity
  always_ff @(posedge clock) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/branch_resolver.sv
`default_nettype none
// ============================================================================
//  Module   : branch_resolver
//  Purpose  : Queues fetch-time predictions, checks them at execute, drives
//             the predictor update bus and the mispredict redirect/flush.
//             Optional macro BRANCH_RESOLVER_STATS_EN adds saturating
//             branch and mispredict counters.
//  Revision : 1.0  initial release
// ============================================================================
module branch_resolver
  import bp_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 3
) (
  input wire logic          clock,
  input wire logic          reset,
  branch_resolver_if.slave  bus
);
  localparam int QW = $clog2(DEPTH) + 1;
  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t        r_state;
  logic [CW-1:0] r_flush_cnt;
  logic          r_write;
  logic [31:0]   r_pc_write;
  logic          r_branch_result;
  logic [31:0]   r_branch_address;
  logic          r_redirect;
  logic [31:0]   r_redirect_pc;
  logic          r_seq_error;

  pred_entry_t   w_entry;
  pred_entry_t   w_head;
  logic [QW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_run;
  logic          w_push;
  logic          w_pop;
  logic          w_pc_mismatch;
  logic          w_mispredict;
  logic          w_clear;

  assign w_run   = (r_state == RUN);
  assign w_entry = '{pc: bus.fetch_pc, taken: bus.pred_taken, target: bus.pred_target};
  // full blocks the push even when a pop frees a slot this cycle
  assign w_push  = bus.fetch_valid & bus.fetch_is_branch & ~w_full & w_run;
  assign w_pop   = bus.ex_valid & ~w_empty & w_run;

  assign w_pc_mismatch = (bus.ex_pc != w_head.pc);
  assign w_mispredict  = (bus.ex_taken != w_head.taken)
                       | (bus.ex_taken & (bus.ex_target != w_head.target))
                       | w_pc_mismatch;
  // wrong-path entries (including a same-cycle push) are discarded
  assign w_clear = w_pop & w_mispredict;

  pred_queue #(.DEPTH(DEPTH)) u_queue (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (w_clear),
    .i_data  (w_entry),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.fetch_stall = (w_count == QW'(DEPTH));

  // Resolver FSM: redirect on mispredict, then hold off traffic while flushing
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= RUN;
      r_flush_cnt   <= '0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_redirect <= 1'b0;
      case (r_state)
        RUN: begin
          if (w_clear) begin
            r_state       <= FLUSH;
            r_flush_cnt   <= CW'(FLUSH_CYCLES - 1);
            r_redirect    <= 1'b1;
            r_redirect_pc <= bus.ex_taken ? bus.ex_target : (bus.ex_pc + PC_STEP);
          end
        end
        FLUSH: begin
          if (r_flush_cnt == '0) r_state <= RUN;
          else                   r_flush_cnt <= r_flush_cnt - 1'b1;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  // Predictor update bus, one strobe per resolved branch
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_write          <= 1'b0;
      r_pc_write       <= '0;
      r_branch_result  <= 1'b0;
      r_branch_address <= '0;
    end else begin
      r_write <= w_pop;
      if (w_pop) begin
        r_pc_write       <= bus.ex_pc;
        r_branch_result  <= bus.ex_taken;
        r_branch_address <= bus.ex_target;
      end
    end
  end

  // Sticky ordering error: resolution with nothing queued or wrong PC at head
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_seq_error <= 1'b0;
    end else if (w_run && bus.ex_valid && (w_empty || w_pc_mismatch)) begin
      r_seq_error <= 1'b1;
    end
  end

  assign bus.write          = r_write;
  assign bus.pc_write       = r_pc_write;
  assign bus.branch_result  = r_branch_result;
  assign bus.branch_address = r_branch_address;
  assign bus.redirect       = r_redirect;
  assign bus.redirect_pc    = r_redirect_pc;
  assign bus.seq_error      = r_seq_error;

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  // Saturating statistics counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (w_pop && (r_stat_branches != '1))
        r_stat_branches <= r_stat_branches + 1'b1;
      if (w_clear && (r_stat_mispredicts != '1))
        r_stat_mispredicts <= r_stat_mispredicts + 1'b1;
    end
  end

  assign bus.stat_branches    = r_stat_branches;
  assign bus.stat_mispredicts = r_stat_mispredicts;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_resolver
//  Purpose  : Directed self-checking bench for branch_resolver
//             (DEPTH=4, FLUSH_CYCLES=3).
//  Revision : 1.0  initial release
// ============================================================================
module tb_branch_resolver;
  logic clock;
  logic reset;
  int   checks;
  int   failures;

  branch_resolver_if bif ();

  branch_resolver #(.DEPTH(4), .FLUSH_CYCLES(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
    bif.fetch_valid     = 1'b1;
    bif.fetch_is_branch = 1'b1;
    bif.fetch_pc        = pc;
    bif.pred_taken      = pt;
    bif.pred_target     = tgt;
  endtask

  task automatic fetch_off();
    bif.fetch_valid     = 1'b0;
    bif.fetch_is_branch = 1'b0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    bif.ex_valid  = 1'b1;
    bif.ex_pc     = pc;
    bif.ex_taken  = t;
    bif.ex_target = tgt;
  endtask

  task automatic ex_off();
    bif.ex_valid = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bif.fetch_pc    = '0;
    bif.pred_taken  = 1'b0;
    bif.pred_target = '0;
    bif.ex_pc       = '0;
    bif.ex_taken    = 1'b0;
    bif.ex_target   = '0;
    fetch_off();
    ex_off();
    #2;
    chk("rst_write",    bif.write,       0);
    chk("rst_redirect", bif.redirect,    0);
    chk("rst_seq",      bif.seq_error,   0);
    chk("rst_stall",    bif.fetch_stall, 0);
    chk("rst_pcw",      bif.pc_write,    0);
    repeat (2) tick();
    reset = 1'b0;

    // Correct taken prediction
    fetch(32'h100, 1'b1, 32'h200); tick(); fetch_off();
    resolve(32'h100, 1'b1, 32'h200); tick(); ex_off();
    chk("t1_write", bif.write,          1);
    chk("t1_pcw",   bif.pc_write,       32'h100);
    chk("t1_res",   bif.branch_result,  1);
    chk("t1_addr",  bif.branch_address, 32'h200);
    chk("t1_redir", bif.redirect,       0);
    tick();
    chk("t1_write_pulse", bif.write, 0);

    // Predicted not-taken, actually taken
    fetch(32'h104, 1'b0, 32'h0); tick(); fetch_off();
    resolve(32'h104, 1'b1, 32'h400); tick(); ex_off();
    chk("t2_redir", bif.redirect,    1);
    chk("t2_rpc",   bif.redirect_pc, 32'h400);
    chk("t2_write", bif.write,       1);
    chk("t2_stall", bif.fetch_stall, 0);
    // pushes offered during the three flush cycles must be dropped
    fetch(32'h600, 1'b1, 32'h640); tick();
    chk("t2_redir_pulse", bif.redirect, 0);
    chk("t2_flush_stall", bif.fetch_stall, 0);
    tick(); tick();
    fetch(32'h500, 1'b0, 32'h0); tick(); fetch_off();
    resolve(32'h500, 1'b0, 32'h0); tick(); ex_off();
    chk("t2_after_write", bif.write,     1);
    chk("t2_after_pcw",   bif.pc_write,  32'h500);
    chk("t2_after_redir", bif.redirect,  0);
    chk("t2_after_seq",   bif.seq_error, 0);

    // Predicted taken, actually not-taken
    fetch(32'h108, 1'b1, 32'h300); tick(); fetch_off();
    resolve(32'h108, 1'b0, 32'h300); tick(); ex_off();
    chk("t3_redir", bif.redirect,      1);
    chk("t3_rpc",   bif.redirect_pc,   32'h10C);
    chk("t3_res",   bif.branch_result, 0);
    repeat (3) tick();

    // Fill the queue, block the fifth push, then free one slot
    for (int i = 0; i < 4; i++) begin
      fetch(32'h10 + 32'(4 * i), 1'b0, 32'h0);
      tick();
    end
    chk("t4_stall", bif.fetch_stall, 1);
    fetch(32'h20, 1'b0, 32'h0); tick();
    chk("t4_stall_held", bif.fetch_stall, 1);
    resolve(32'h10, 1'b0, 32'h0); tick(); ex_off();
    chk("t4_write",      bif.write,       1);
    chk("t4_stall_pop",  bif.fetch_stall, 0);
    tick(); fetch_off();
    chk("t4_stall_refill", bif.fetch_stall, 1);
    for (int i = 0; i < 4; i++) begin
      resolve(32'h14 + 32'(4 * i), 1'b0, 32'h0);
      tick();
      chk("t4_drain_pcw",   bif.pc_write, 32'h14 + 32'(4 * i));
      chk("t4_drain_redir", bif.redirect, 0);
    end
    ex_off();
    chk("t4_seq", bif.seq_error, 0);

    // Resolution with an empty queue, then a PC mismatch
    resolve(32'h999, 1'b0, 32'h0); tick(); ex_off();
    chk("t5_seq",   bif.seq_error, 1);
    chk("t5_write", bif.write,     0);
    chk("t5_redir", bif.redirect,  0);
    fetch(32'h300, 1'b1, 32'h340); tick(); fetch_off();
    resolve(32'h200, 1'b1, 32'h340); tick(); ex_off();
    chk("t5_mm_redir", bif.redirect,    1);
    chk("t5_mm_seq",   bif.seq_error,   1);
    chk("t5_mm_rpc",   bif.redirect_pc, 32'h340);
    chk("t5_mm_pcw",   bif.pc_write,    32'h200);

    // Asynchronous reset in the middle of FLUSH
    tick();
    reset = 1'b1;
    #1;
    chk("rst2_write",    bif.write,          0);
    chk("rst2_redirect", bif.redirect,       0);
    chk("rst2_rpc",      bif.redirect_pc,    0);
    chk("rst2_seq",      bif.seq_error,      0);
    chk("rst2_pcw",      bif.pc_write,       0);
    chk("rst2_res",      bif.branch_result,  0);
    chk("rst2_addr",     bif.branch_address, 0);
    chk("rst2_stall",    bif.fetch_stall,    0);
    #2;
    reset = 1'b0;
    fetch(32'h700, 1'b1, 32'h740); tick(); fetch_off();
    resolve(32'h700, 1'b1, 32'h740); tick(); ex_off();
    chk("t6_write", bif.write,     1);
    chk("t6_pcw",   bif.pc_write,  32'h700);
    chk("t6_redir", bif.redirect,  0);
    chk("t6_seq",   bif.seq_error, 0);

    // Fall-through PC wraps at the top of the address space
    fetch(32'hFFFF_FFFC, 1'b1, 32'h10); tick(); fetch_off();
    resolve(32'hFFFF_FFFC, 1'b0, 32'h10); tick(); ex_off();
    chk("t7_redir", bif.redirect,      1);
    chk("t7_rpc",   bif.redirect_pc,   32'h0);
    chk("t7_res",   bif.branch_result, 0);
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
